alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Sequencer that drives the 32-bit ALU datapath (operand ROMs A/B, ALUNBits, display decoders) through a batch of operand pairs without manual switch changes. On start it steps both ROM addresses from a programmed first to last entry, and applies a latched operation, invert and carry-in to each pair. It waits a programmable settle time, captures result and carry-out, and presents each result to the display/consumer stage over a valid/ready handshake. Optional carry chaining feeds each carry-out into the next pair's carry-in (multi-word add/sub).

Parameters:
N, 32, ALU data width
ADDR_W, 3, ROM address width
SETTLE_CYC, 2, cycles between address/op change and result capture (>=1)

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  single-cycle start pulse; ignored unless IDLE or DONE
first_addr_i  input  ADDR_W  first ROM address of batch
last_addr_i  input  ADDR_W  last ROM address of batch (wraps past max if < first)
op_i  input  4  ALU operation code, latched at start
invert_i  input  1  ALU invert, latched at start
c_i  input  1  initial carry-in, latched at start
chain_i  input  1  1 = carry-out of pair k becomes carry-in of pair k+1; latched at start
abort_i  input  1  synchronous abort to IDLE
addra_o  output  ADDR_W  address to ROM A
addrb_o  output  ADDR_W  address to ROM B (always equals addra_o)
operacion_o  output  4  operation to ALU
invert_o  output  1  invert to ALU
c_o  output  1  carry-in to ALU
alu_res_i  input  N  ALU result
alu_c_i  input  1  ALU carry-out
res_o  output  N  captured result
res_c_o  output  1  captured carry-out
res_addr_o  output  ADDR_W  address that produced res_o
res_valid_o  output  1  result handshake valid
res_ready_i  input  1  result handshake ready
busy_o  output  1  high in any state except IDLE/DONE
done_o  output  1  high in DONE

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0; latched config 0; settle counter 0.
- States: IDLE, ISSUE, SETTLE, CAPTURE, HOLD, DONE.
- IDLE/DONE + start_i: latch op/invert/c/chain/first/last; addr<=first_addr_i; carry reg<=c_i; go ISSUE; clear done_o.
- ISSUE (1 cycle): drive addra_o=addrb_o=addr, operacion_o, invert_o, c_o=carry reg; load counter with SETTLE_CYC-1; go SETTLE.
- SETTLE: decrement per cycle; at 0 go CAPTURE. Issue-to-capture latency = SETTLE_CYC+1 cycles.
- CAPTURE (1 cycle): res_o<=alu_res_i, res_c_o<=alu_c_i, res_addr_o<=addr; res_valid_o<=1; if chain, carry reg<=alu_c_i (else keep c_i); go HOLD.
- HOLD: res_valid_o held, and res_o/res_c_o/res_addr_o held stable until res_ready_i=1 while res_valid_o=1. On transfer: res_valid_o<=0. If addr==last go DONE, else addr<=addr+1 (mod 2^ADDR_W) and go ISSUE. No new capture while valid is pending (no overwrite).
- Wrap: last<first runs first..max,0..last. first==last runs exactly one pair. Full batch is at most 2^ADDR_W pairs.
- DONE: done_o=1; outputs to ALU and res_* hold last values; start_i restarts.
- start_i while busy: ignored.
- abort_i (any state): next cycle IDLE, res_valid_o=0, busy_o=0, done_o=0; res_* hold. abort_i has priority over start_i and res_ready_i.
- Reset mid-batch: immediate return to reset values; no partial handshake completes.
- ALU control outputs remain driven with latched values from ISSUE through HOLD.

Test Plan:
- Reset mid-SETTLE (rst_i pulsed asynchronously between clock edges) -> all outputs 0 immediately; state IDLE; later start_i runs normally.
- first=0, last=3, op=add, chain=0, res_ready_i=1 constant, SETTLE_CYC=2 -> 4 results, res_addr_o 0,1,2,3. Each is captured 3 cycles after its ISSUE, and each res_o equals the ROM A+B reference sum. done_o follows the last transfer.
- chain=1, c_i=0, first=6, last=1 (wrap) -> addresses 6,7,0,1. c_o of each pair equals res_c_o of the previous pair; use a ROM pair with 0xFFFFFFFF+1 to force carry=1 into the next pair.
- res_ready_i held 0 for 10 cycles after the first valid -> res_valid_o stays 1 and res_o stays stable; addra_o does not advance; transfer occurs on the first ready cycle.
- abort_i asserted during HOLD with valid pending -> next cycle IDLE, res_valid_o=0, busy_o=0. start_i in the same cycle as abort_i is ignored.
- start_i pulsed during the run, and first==last=5 -> the mid-run pulse has no effect. The first==last batch produces exactly one result at res_addr_o=5, then DONE.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Bus bundle between the ALU batch sequencer and its environment:
// batch control, ALU datapath drive/return, result handshake and status.
interface alu_sequencer_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 3
);
  // Batch control
  logic              start_i;
  logic [ADDR_W-1:0] first_addr_i;
  logic [ADDR_W-1:0] last_addr_i;
  logic [3:0]        op_i;
  logic              invert_i;
  logic              c_i;
  logic              chain_i;
  logic              abort_i;

  // Drive to ROMs / ALU
  logic [ADDR_W-1:0] addra_o;
  logic [ADDR_W-1:0] addrb_o;
  logic [3:0]        operacion_o;
  logic              invert_o;
  logic              c_o;

  // Return from ALU
  logic [N-1:0]      alu_res_i;
  logic              alu_c_i;

  // Result handshake toward display/consumer
  logic [N-1:0]      res_o;
  logic              res_c_o;
  logic [ADDR_W-1:0] res_addr_o;
  logic              res_valid_o;
  logic              res_ready_i;

  // Status
  logic              busy_o;
  logic              done_o;

  // Sequencer side
  modport master (
    input  start_i, first_addr_i, last_addr_i, op_i, invert_i, c_i, chain_i,
           abort_i, alu_res_i, alu_c_i, res_ready_i,
    output addra_o, addrb_o, operacion_o, invert_o, c_o,
           res_o, res_c_o, res_addr_o, res_valid_o, busy_o, done_o
  );

  // Environment side (ROMs, ALU, consumer, controller)
  modport slave (
    output start_i, first_addr_i, last_addr_i, op_i, invert_i, c_i, chain_i,
           abort_i, alu_res_i, alu_c_i, res_ready_i,
    input  addra_o, addrb_o, operacion_o, invert_o, c_o,
           res_o, res_c_o, res_addr_o, res_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_sequencer.sv
// Batch sequencer for the ALU datapath: walks both operand ROM addresses
// from first to last (with wrap), waits a settle time per pair, captures
// result/carry-out and hands each result over a valid/ready handshake.
// Optional carry chaining turns the batch into a multi-word add/sub.
module alu_sequencer #(
  parameter int N          = 32,
  parameter int ADDR_W     = 3,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  alu_sequencer_if.master  bus
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    HOLD    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [ADDR_W-1:0] last_q,      last_d;
  logic [3:0]        op_q,        op_d;
  logic              inv_q,       inv_d;
  logic              chain_q,     chain_d;
  logic              carry_q,     carry_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  // ALU-facing copies, only reloaded when a pair is issued so the ALU
  // sees stable controls from ISSUE through HOLD even if carry_q moves.
  logic [ADDR_W-1:0] alu_addr_q,  alu_addr_d;
  logic [3:0]        alu_op_q,    alu_op_d;
  logic              alu_inv_q,   alu_inv_d;
  logic              alu_c_q,     alu_c_d;
  logic [N-1:0]      res_q,       res_d;
  logic              res_c_q,     res_c_d;
  logic [ADDR_W-1:0] res_addr_q,  res_addr_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;

  // Next-state and next-output computation for the whole sequencer
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_d      = last_q;
    op_d        = op_q;
    inv_d       = inv_q;
    chain_d     = chain_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    alu_addr_d  = alu_addr_q;
    alu_op_d    = alu_op_q;
    alu_inv_d   = alu_inv_q;
    alu_c_d     = alu_c_q;
    res_d       = res_q;
    res_c_d     = res_c_q;
    res_addr_d  = res_addr_q;
    res_valid_d = res_valid_q;

    if (bus.abort_i) begin
      // Abort wins over start and ready; captured results stay visible.
      state_d     = IDLE;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start_i) begin
            op_d       = bus.op_i;
            inv_d      = bus.invert_i;
            chain_d    = bus.chain_i;
            carry_d    = bus.c_i;
            addr_d     = bus.first_addr_i;
            last_d     = bus.last_addr_i;
            alu_addr_d = bus.first_addr_i;
            alu_op_d   = bus.op_i;
            alu_inv_d  = bus.invert_i;
            alu_c_d    = bus.c_i;
            state_d    = ISSUE;
          end
        end
        ISSUE: begin
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
          state_d = SETTLE;
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        CAPTURE: begin
          res_d       = bus.alu_res_i;
          res_c_d     = bus.alu_c_i;
          res_addr_d  = addr_q;
          res_valid_d = 1'b1;
          if (chain_q) begin
            carry_d = bus.alu_c_i;
          end
          state_d = HOLD;
        end
        HOLD: begin
          if (res_valid_q && bus.res_ready_i) begin
            res_valid_d = 1'b0;
            if (addr_q == last_q) begin
              state_d = DONE;
            end else begin
              addr_d     = addr_q + ADDR_W'(1);
              alu_addr_d = addr_q + ADDR_W'(1);
              alu_op_d   = op_q;
              alu_inv_d  = inv_q;
              alu_c_d    = carry_q;
              state_d    = ISSUE;
            end
          end
        end
        default: begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; async reset returns everything to zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_q      <= '0;
      op_q        <= '0;
      inv_q       <= 1'b0;
      chain_q     <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      alu_addr_q  <= '0;
      alu_op_q    <= '0;
      alu_inv_q   <= 1'b0;
      alu_c_q     <= 1'b0;
      res_q       <= '0;
      res_c_q     <= 1'b0;
      res_addr_q  <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      op_q        <= op_d;
      inv_q       <= inv_d;
      chain_q     <= chain_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      alu_addr_q  <= alu_addr_d;
      alu_op_q    <= alu_op_d;
      alu_inv_q   <= alu_inv_d;
      alu_c_q     <= alu_c_d;
      res_q       <= res_d;
      res_c_q     <= res_c_d;
      res_addr_q  <= res_addr_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.addra_o     = alu_addr_q;
  assign bus.addrb_o     = alu_addr_q;
  assign bus.operacion_o = alu_op_q;
  assign bus.invert_o    = alu_inv_q;
  assign bus.c_o         = alu_c_q;
  assign bus.res_o       = res_q;
  assign bus.res_c_o     = res_c_q;
  assign bus.res_addr_o  = res_addr_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: operand ROMs and a reference ALU sit
// around the DUT; expected results are hand-computed constants.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  alu_sequencer_if #(.N(32), .ADDR_W(3)) bus ();

  alu_sequencer #(.N(32), .ADDR_W(3), .SETTLE_CYC(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] rom_a(input logic [2:0] a);
    case (a)
      3'd0: rom_a = 32'h0000_0001;
      3'd1: rom_a = 32'h0000_0010;
      3'd2: rom_a = 32'h1234_5678;
      3'd3: rom_a = 32'hFFFF_FFFF;
      3'd4: rom_a = 32'h0000_0005;
      3'd5: rom_a = 32'h8000_0000;
      3'd6: rom_a = 32'hFFFF_FFFF;
      default: rom_a = 32'h0000_0002;
    endcase
  endfunction

  function automatic logic [31:0] rom_b(input logic [2:0] a);
    case (a)
      3'd0: rom_b = 32'h0000_0002;
      3'd1: rom_b = 32'h0000_0020;
      3'd2: rom_b = 32'h1111_1111;
      3'd3: rom_b = 32'h0000_0001;
      3'd4: rom_b = 32'h0000_0003;
      3'd5: rom_b = 32'h8000_0000;
      3'd6: rom_b = 32'h0000_0001;
      default: rom_b = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Combinational ALU fed by the ROMs (op 0 = add, others = AND)
  logic [32:0] sum;
  logic [31:0] opb;
  always_comb begin
    opb = bus.invert_o ? ~rom_b(bus.addrb_o) : rom_b(bus.addrb_o);
    sum = {1'b0, rom_a(bus.addra_o)} + {1'b0, opb} + {32'd0, bus.c_o};
    if (bus.operacion_o == 4'd0) begin
      bus.alu_res_i = sum[31:0];
      bus.alu_c_i   = sum[32];
    end else begin
      bus.alu_res_i = rom_a(bus.addra_o) & opb;
      bus.alu_c_i   = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_batch(input logic [2:0] first, input logic [2:0] last,
                             input logic c, input logic chain);
    bus.first_addr_i = first;
    bus.last_addr_i  = last;
    bus.op_i         = 4'd0;
    bus.invert_i     = 1'b0;
    bus.c_i          = c;
    bus.chain_i      = chain;
    bus.start_i      = 1'b1;
    tick();
    bus.start_i      = 1'b0;
    $display("start batch first=%0d last=%0d c=%0d chain=%0d", first, last, c, chain);
  endtask

  // Advances until res_valid_o is seen; n = negedges waited
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.res_valid_o && n < 60);
    if (!bus.res_valid_o) check("valid_timeout", {63'd0, bus.res_valid_o}, 64'd1);
  endtask

  logic [2:0]  exp_addr [4];
  logic [31:0] exp_res  [4];
  logic        exp_c    [4];
  logic        exp_ci   [4];
  logic [31:0] held;
  int          n;

  initial begin
    bus.start_i = 1'b0;  bus.first_addr_i = '0; bus.last_addr_i = '0;
    bus.op_i = '0;       bus.invert_i = 1'b0;   bus.c_i = 1'b0;
    bus.chain_i = 1'b0;  bus.abort_i = 1'b0;    bus.res_ready_i = 1'b0;

    // Reset values
    tick();
    check("rst_busy",  {63'd0, bus.busy_o}, 64'd0);
    check("rst_done",  {63'd0, bus.done_o}, 64'd0);
    check("rst_valid", {63'd0, bus.res_valid_o}, 64'd0);
    check("rst_res",   {32'd0, bus.res_o}, 64'd0);
    check("rst_addra", {61'd0, bus.addra_o}, 64'd0);
    rst = 1'b0;
    tick();

    // Async reset in the middle of SETTLE
    start_batch(3'd2, 3'd3, 1'b1, 1'b0);
    check("issue_addra", {61'd0, bus.addra_o}, 64'd2);
    check("issue_addrb", {61'd0, bus.addrb_o}, 64'd2);
    check("issue_c",     {63'd0, bus.c_o}, 64'd1);
    check("issue_busy",  {63'd0, bus.busy_o}, 64'd1);
    tick();
    #2 rst = 1'b1;
    #1;
    $display("async reset during settle");
    check("arst_addra", {61'd0, bus.addra_o}, 64'd0);
    check("arst_c",     {63'd0, bus.c_o}, 64'd0);
    check("arst_busy",  {63'd0, bus.busy_o}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Plain batch 0..3, ready always high
    bus.res_ready_i = 1'b1;
    exp_res = '{32'h0000_0003, 32'h0000_0030, 32'h2345_6789, 32'h0000_0000};
    exp_c   = '{1'b0, 1'b0, 1'b0, 1'b1};
    start_batch(3'd0, 3'd3, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_valid(n);
      $display("batch1 pair %0d addr=%0d res=0x%08h c=%0b lat=%0d", k, bus.res_addr_o, bus.res_o, bus.res_c_o, n);
      check("b1_latency", 64'(n), (k == 0) ? 64'd4 : 64'd5);
      check("b1_addr", {61'd0, bus.res_addr_o}, 64'(k));
      check("b1_res",  {32'd0, bus.res_o}, {32'd0, exp_res[k]});
      check("b1_c",    {63'd0, bus.res_c_o}, {63'd0, exp_c[k]});
    end
    tick();
    check("b1_done",  {63'd0, bus.done_o}, 64'd1);
    check("b1_busy",  {63'd0, bus.busy_o}, 64'd0);
    check("b1_valid", {63'd0, bus.res_valid_o}, 64'd0);

    // Chained, wrapping batch 6,7,0,1 started from DONE
    exp_addr = '{3'd6, 3'd7, 3'd0, 3'd1};
    exp_res  = '{32'h0000_0000, 32'h0000_0002, 32'h0000_0004, 32'h0000_0030};
    exp_c    = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_ci   = '{1'b0, 1'b1, 1'b1, 1'b0};
    start_batch(3'd6, 3'd1, 1'b0, 1'b1);
    check("b2_done_clr", {63'd0, bus.done_o}, 64'd0);
    for (int k = 0; k < 4; k++) begin
      wait_valid(n);
      $display("batch2 pair %0d addr=%0d res=0x%08h c=%0b cin=%0b", k, bus.res_addr_o, bus.res_o, bus.res_c_o, bus.c_o);
      check("b2_addr", {61'd0, bus.res_addr_o}, {61'd0, exp_addr[k]});
      check("b2_res",  {32'd0, bus.res_o}, {32'd0, exp_res[k]});
      check("b2_c",    {63'd0, bus.res_c_o}, {63'd0, exp_c[k]});
      check("b2_cin",  {63'd0, bus.c_o}, {63'd0, exp_ci[k]});
    end
    tick();
    check("b2_done", {63'd0, bus.done_o}, 64'd1);

    // Back-pressure: ready low for 10 cycles after first valid
    bus.res_ready_i = 1'b0;
    start_batch(3'd2, 3'd3, 1'b0, 1'b0);
    wait_valid(n);
    held = bus.res_o;
    check("bp_res", {32'd0, bus.res_o}, 64'h2345_6789);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_valid", {63'd0, bus.res_valid_o}, 64'd1);
      check("bp_stable", {32'd0, bus.res_o}, {32'd0, held});
      check("bp_addra", {61'd0, bus.addra_o}, 64'd2);
    end
    $display("backpressure held 10 cycles res=0x%08h", bus.res_o);
    bus.res_ready_i = 1'b1;
    tick();
    check("bp_xfer_valid", {63'd0, bus.res_valid_o}, 64'd0);
    check("bp_xfer_addra", {61'd0, bus.addra_o}, 64'd3);
    wait_valid(n);
    check("bp_res2",  {32'd0, bus.res_o}, 64'h0);
    check("bp_c2",    {63'd0, bus.res_c_o}, 64'd1);
    check("bp_addr2", {61'd0, bus.res_addr_o}, 64'd3);
    tick();
    check("bp_done", {63'd0, bus.done_o}, 64'd1);

    // Abort in HOLD with a pending result; simultaneous start ignored
    bus.res_ready_i = 1'b0;
    start_batch(3'd0, 3'd3, 1'b0, 1'b0);
    wait_valid(n);
    bus.abort_i = 1'b1;
    bus.start_i = 1'b1;
    bus.first_addr_i = 3'd4;
    tick();
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
    $display("abort in hold: valid=%0b busy=%0b res=0x%08h", bus.res_valid_o, bus.busy_o, bus.res_o);
    check("ab_valid", {63'd0, bus.res_valid_o}, 64'd0);
    check("ab_busy",  {63'd0, bus.busy_o}, 64'd0);
    check("ab_done",  {63'd0, bus.done_o}, 64'd0);
    check("ab_res",   {32'd0, bus.res_o}, 64'd3);
    check("ab_raddr", {61'd0, bus.res_addr_o}, 64'd0);
    repeat (3) tick();
    check("ab_idle", {63'd0, bus.busy_o}, 64'd0);

    // Single-pair batch with a stray start pulse mid-run
    bus.res_ready_i = 1'b1;
    start_batch(3'd5, 3'd5, 1'b0, 1'b0);
    bus.first_addr_i = 3'd0;
    bus.last_addr_i  = 3'd3;
    bus.start_i      = 1'b1;
    tick();
    bus.start_i      = 1'b0;
    wait_valid(n);
    $display("single pair addr=%0d res=0x%08h c=%0b", bus.res_addr_o, bus.res_o, bus.res_c_o);
    check("sp_addr", {61'd0, bus.res_addr_o}, 64'd5);
    check("sp_res",  {32'd0, bus.res_o}, 64'd0);
    check("sp_c",    {63'd0, bus.res_c_o}, 64'd1);
    tick();
    check("sp_done", {63'd0, bus.done_o}, 64'd1);
    repeat (8) tick();
    check("sp_novalid", {63'd0, bus.res_valid_o}, 64'd0);
    check("sp_addra",   {61'd0, bus.addra_o}, 64'd5);
    check("sp_still_done", {63'd0, bus.done_o}, 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
